a2d_intf: RTL and testbench

Round-robin SPI master for the external 8-channel, 12-bit A2D converter on the eBike board. Periodically converts the battery, current, torque and (optionally) brake channels and holds each result in a register. These registers drive the `batt`, `curr` and `torque` inputs of the sensor-conditioning stage directly downstream.

---
 rtl/a2d_pkg.sv | 24 ++
 rtl/spi_mnrch.sv | 76 +++++++
 rtl/a2d_intf.sv | 148 ++++++++++++++
 tb/tb_a2d_intf.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/a2d_pkg.sv
// Shared constants and types for the A2D round-robin interface and its SPI master.
`timescale 1ns/1ps
package a2d_pkg;

    localparam logic [2:0] CH_BATT   = 3'd0;
    localparam logic [2:0] CH_CURR   = 3'd1;
    localparam logic [2:0] CH_BRAKE  = 3'd3;
    localparam logic [2:0] CH_TORQUE = 3'd4;

    localparam logic [10:0] CMD_PAD = 11'h000;

    typedef enum logic [1:0] {
        IDLE,
        CMD,
        GAP,
        READ
    } a2d_state_e;

    // Conversion command: channel select in bits [13:11], everything else zero.
    function automatic logic [15:0] a2d_cmd(input logic [2:0] chnl);
        return {2'b00, chnl, CMD_PAD};
    endfunction

endpackage

// File: rtl/spi_mnrch.sv
// 16-bit SPI master (mode 3, MSB first) with SCLK = clk/32; a transaction ends with a one-clk done pulse.
`timescale 1ns/1ps
module spi_mnrch (
    input  logic        clk,
    input  logic        rst,
    input  logic        wrt,
    input  logic [15:0] cmd,
    output logic        done,
    output logic [15:0] rd_data,
    output logic        SS_n,
    output logic        SCLK,
    output logic        MOSI,
    input  logic        MISO
);

    logic        ss_n_q, ss_n_d;
    logic [4:0]  div_q, div_d;
    logic [4:0]  bit_q, bit_d;
    logic [15:0] shft_q, shft_d;
    logic        miso_q, miso_d;
    logic        done_q, done_d;

    // SCLK rises when div wraps 31->0; MISO is captured on that edge and shifted in one clk later.
    always_comb begin
        ss_n_d = ss_n_q;
        div_d  = div_q;
        bit_d  = bit_q;
        shft_d = shft_q;
        miso_d = miso_q;
        done_d = 1'b0;
        if (wrt) begin
            ss_n_d = 1'b0;
            div_d  = 5'd0;
            bit_d  = 5'd0;
            shft_d = cmd;
        end else if (!ss_n_q) begin
            div_d = div_q + 5'd1;
            if (div_q == 5'd31) begin
                miso_d = MISO;
                bit_d  = bit_q + 5'd1;
            end
            if ((div_q == 5'd0) && (bit_q != 5'd0)) begin
                shft_d = {shft_q[14:0], miso_q};
            end
            if ((div_q == 5'd15) && (bit_q == 5'd16)) begin
                ss_n_d = 1'b1;
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ss_n_q <= 1'b1;
            div_q  <= 5'd0;
            bit_q  <= 5'd0;
            shft_q <= 16'h0000;
            miso_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            ss_n_q <= ss_n_d;
            div_q  <= div_d;
            bit_q  <= bit_d;
            shft_q <= shft_d;
            miso_q <= miso_d;
            done_q <= done_d;
        end
    end

    assign SS_n    = ss_n_q;
    assign SCLK    = ss_n_q | ~div_q[4];
    assign MOSI    = shft_q[15];
    assign rd_data = shft_q;
    assign done    = done_q;

endmodule

// File: rtl/a2d_intf.sv
// Round-robin A2D reader: interval timer, two-transaction-per-channel FSM and result registers.
// Define A2D_BRAKE_CH_EN to add the brake channel (3) to the rotation and the brake output.
`timescale 1ns/1ps
module a2d_intf
    import a2d_pkg::*;
#(
    parameter int FAST_SIM = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MISO,
    output logic        SS_n,
    output logic        SCLK,
    output logic        MOSI,
    output logic [11:0] batt,
    output logic [11:0] curr,
`ifdef A2D_BRAKE_CH_EN
    output logic [11:0] brake,
`endif
    output logic [11:0] torque
);

    localparam int TMR_W = (FAST_SIM != 0) ? 11 : 14;

    logic [TMR_W-1:0] tmr_q, tmr_d;
    a2d_state_e       state_q, state_d;
    logic [1:0]       ptr_q, ptr_d;
    logic [11:0]      batt_q, batt_d, curr_q, curr_d, torque_q, torque_d;
`ifdef A2D_BRAKE_CH_EN
    logic [11:0]      brake_q, brake_d;
`endif
    logic [2:0]       chnl;
    logic             wrt, done, load;
    logic [15:0]      rd_data;
    logic             unused_rd_hi;

    assign tmr_d        = tmr_q + {{(TMR_W-1){1'b0}}, 1'b1};
    assign unused_rd_hi = ^rd_data[15:12];

    always_comb begin
        chnl = CH_BATT;
        case (ptr_q)
            2'd0: chnl = CH_BATT;
            2'd1: chnl = CH_CURR;
`ifdef A2D_BRAKE_CH_EN
            2'd2: chnl = CH_BRAKE;
            2'd3: chnl = CH_TORQUE;
`else
            2'd2: chnl = CH_TORQUE;
`endif
            default: chnl = CH_BATT;
        endcase
    end

    // Expiries outside IDLE are simply dropped; the pointer only advances on a completed READ.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        wrt     = 1'b0;
        load    = 1'b0;
        case (state_q)
            IDLE: if (&tmr_q) begin
                wrt     = 1'b1;
                state_d = CMD;
            end
            CMD: if (done) state_d = GAP;
            GAP: begin
                wrt     = 1'b1;
                state_d = READ;
            end
            READ: if (done) begin
                load    = 1'b1;
                state_d = IDLE;
`ifdef A2D_BRAKE_CH_EN
                ptr_d   = ptr_q + 2'd1;
`else
                ptr_d   = (ptr_q == 2'd2) ? 2'd0 : ptr_q + 2'd1;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        batt_d   = batt_q;
        curr_d   = curr_q;
        torque_d = torque_q;
`ifdef A2D_BRAKE_CH_EN
        brake_d  = brake_q;
`endif
        if (load) begin
            case (chnl)
                CH_BATT:   batt_d   = rd_data[11:0];
                CH_CURR:   curr_d   = rd_data[11:0];
`ifdef A2D_BRAKE_CH_EN
                CH_BRAKE:  brake_d  = rd_data[11:0];
`endif
                CH_TORQUE: torque_d = rd_data[11:0];
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmr_q    <= '0;
            state_q  <= IDLE;
            ptr_q    <= 2'd0;
            batt_q   <= 12'h000;
            curr_q   <= 12'h000;
            torque_q <= 12'h000;
`ifdef A2D_BRAKE_CH_EN
            brake_q  <= 12'h000;
`endif
        end else begin
            tmr_q    <= tmr_d;
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            batt_q   <= batt_d;
            curr_q   <= curr_d;
            torque_q <= torque_d;
`ifdef A2D_BRAKE_CH_EN
            brake_q  <= brake_d;
`endif
        end
    end

    spi_mnrch u_spi (
        .clk     (clk),
        .rst     (rst),
        .wrt     (wrt),
        .cmd     (a2d_cmd(chnl)),
        .done    (done),
        .rd_data (rd_data),
        .SS_n    (SS_n),
        .SCLK    (SCLK),
        .MOSI    (MOSI),
        .MISO    (MISO)
    );

    assign batt   = batt_q;
    assign curr   = curr_q;
    assign torque = torque_q;
`ifdef A2D_BRAKE_CH_EN
    assign brake  = brake_q;
`endif

endmodule

// File: tb/tb_a2d_intf.sv
// Scoreboard bench for a2d_intf: behavioural A2D slave, randomized channel values, timing and hold checks.
`timescale 1ns/1ps
module tb_a2d_intf;

`ifdef A2D_BRAKE_CH_EN
    localparam int NCH = 4;
    int order [NCH] = '{0, 1, 3, 4};
`else
    localparam int NCH = 3;
    int order [NCH] = '{0, 1, 4};
`endif

    typedef struct packed {
        logic [2:0]       ch;
        logic [7:0][11:0] old_r;
        logic [7:0][11:0] new_r;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        MISO;
    logic        SS_n, SCLK, MOSI;
    logic [11:0] batt, curr, torque;
`ifdef A2D_BRAKE_CH_EN
    logic [11:0] brake;
`endif

    int               checks = 0;
    int               failures = 0;
    exp_t             sb [$];
    logic [15:0]      cmd_q [$];
    logic [11:0]      chan_val [8];
    logic [7:0][11:0] model_regs;
    bit               mon_en = 1'b0;
    int               done_cnt = 0;
    longint           last_start = 0;
    int               prev_ch = 0;
    logic [15:0]      a2d_tx, a2d_rx;
    bit               a2d_abort;

    a2d_intf dut (
        .clk    (clk),
        .rst    (rst),
        .MISO   (MISO),
        .SS_n   (SS_n),
        .SCLK   (SCLK),
        .MOSI   (MOSI),
        .batt   (batt),
        .curr   (curr),
`ifdef A2D_BRAKE_CH_EN
        .brake  (brake),
`endif
        .torque (torque)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp_v);
        end
    endtask

    function automatic logic [11:0] dut_reg(input int ch);
        case (ch)
            0: return batt;
            1: return curr;
`ifdef A2D_BRAKE_CH_EN
            3: return brake;
`endif
            4: return torque;
            default: return 12'h000;
        endcase
    endfunction

    task automatic checkRegs(input string tag, input logic [7:0][11:0] exp_r);
        for (int i = 0; i < NCH; i++) begin
            checkOutput($sformatf("%s_ch%0d", tag, order[i]), 32'(dut_reg(order[i])), 32'(exp_r[order[i]]));
        end
    endtask

    function automatic logic [11:0] plan_val(input int ch);
        case (ch)
            0: return 12'hA98;
            1: return 12'h123;
            3: return 12'h555;
            4: return 12'h7FF;
            default: return 12'h000;
        endcase
    endfunction

    // A2D model: answers each transaction with the channel selected by the previous complete one.
    initial begin
        MISO = 1'b0;
        forever begin
            @(negedge SS_n);
            a2d_tx    = {4'h0, chan_val[prev_ch]};
            a2d_rx    = 16'h0000;
            a2d_abort = 1'b0;
            MISO      = a2d_tx[15];
            for (int b = 0; b < 16; b++) begin
                @(posedge SCLK or posedge SS_n);
                if (SS_n) begin
                    a2d_abort = 1'b1;
                    break;
                end
                a2d_rx = {a2d_rx[14:0], MOSI};
                if (b < 15) begin
                    @(negedge SCLK or posedge SS_n);
                    if (SS_n) begin
                        a2d_abort = 1'b1;
                        break;
                    end
                    MISO = a2d_tx[14-b];
                end
            end
            if (!a2d_abort) begin
                cmd_q.push_back(a2d_rx);
                prev_ch = int'(a2d_rx[13:11]);
            end
        end
    end

    // Monitor: one scoreboard entry per sequence, timed from the first SS_n fall.
    task automatic monitorSequence();
        exp_t   e;
        longint t_start;
        logic [15:0] exp_cmd;
        t_start = $time;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL unexpected_sequence: got sequence expected none");
            return;
        end
        e = sb.pop_front();
        if (last_start != 0) checkOutput("interval", 32'((t_start - last_start) / 10), 32'd2048);
        last_start = t_start;
        repeat (527) @(posedge clk);
        @(negedge clk) checkOutput("ss_low_cmd_end", 32'(SS_n), 32'd0);
        @(posedge clk);
        @(negedge clk);
        checkOutput("ss_high_done", 32'(SS_n), 32'd1);
        checkOutput("sclk_high_done", 32'(SCLK), 32'd1);
        repeat (2) @(posedge clk);
        @(negedge clk) checkOutput("ss_low_read", 32'(SS_n), 32'd0);
        repeat (528) @(posedge clk);
        @(negedge clk) checkRegs("regs_before", e.old_r);
        @(posedge clk);
        @(negedge clk) checkRegs("regs_after", e.new_r);
        exp_cmd = {2'b00, e.ch, 11'h000};
        if (cmd_q.size() < 2) begin
            checks++;
            failures++;
            $display("[TB] FAIL cmd_count: got %0d expected 2", cmd_q.size());
        end else begin
            checkOutput("cmd_first", 32'(cmd_q.pop_front()), 32'(exp_cmd));
            checkOutput("cmd_second", 32'(cmd_q.pop_front()), 32'(exp_cmd));
        end
        done_cnt++;
    endtask

    initial begin
        forever begin
            @(negedge SS_n);
            if (mon_en) monitorSequence();
        end
    end

    task automatic waitSsLow(input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (!SS_n) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("[TB] FAIL ss_fall_timeout: got no SS_n fall expected one within %0d clks", bound);
        end
    endtask

    task automatic applyStimulus(input int k, input bit use_fixed, output bit ok);
        exp_t e;
        int   ch;
        int   target;
        ch = order[k % NCH];
        if (use_fixed) begin
            chan_val[ch] = plan_val(ch);
        end else begin
            while (chan_val[ch] == model_regs[ch]) chan_val[ch] = 12'($urandom_range(0, 4095));
        end
        e.ch       = 3'(ch);
        e.old_r    = model_regs;
        model_regs[ch] = chan_val[ch];
        e.new_r    = model_regs;
        sb.push_back(e);
        target = done_cnt + 1;
        waitSsLow(2200, ok);
        if (!ok) return;
        // Disturb the idle channels while this one is being read back; their registers must hold.
        repeat (600) @(negedge clk);
        if (use_fixed) begin
            if (ch == 4) chan_val[1] = 12'h456;
        end else begin
            for (int c = 0; c < 8; c++) if (c != ch) chan_val[c] = 12'($urandom_range(0, 4095));
        end
        ok = 1'b0;
        for (int i = 0; i < 1200; i++) begin
            @(negedge clk);
            if (done_cnt >= target) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("[TB] FAIL sequence_timeout: got %0d done expected %0d", done_cnt, target);
        end
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_ss_n"}, 32'(SS_n), 32'd1);
        checkOutput({tag, "_sclk"}, 32'(SCLK), 32'd1);
        checkOutput({tag, "_mosi"}, 32'(MOSI), 32'd0);
        checkRegs({tag, "_regs"}, '0);
    endtask

    initial begin
        bit ok;
        rst = 1'b1;
        for (int c = 0; c < 8; c++) chan_val[c] = 12'h000;
        model_regs = '0;
        repeat (3) @(posedge clk);
        @(negedge clk) checkResetOutputs("por");
        rst    = 1'b0;
        mon_en = 1'b1;

        ok = 1'b1;
        for (int k = 0; k < 2 * NCH && ok; k++) applyStimulus(k, (k < NCH), ok);

        if (ok) begin
            // Abort a CMD transaction 300 clks after its wrt cycle.
            mon_en = 1'b0;
            waitSsLow(2200, ok);
            if (ok) begin
                repeat (299) @(posedge clk);
                #2;
                checkRegs("pre_abort", model_regs);
                rst = 1'b1;
                #1 checkResetOutputs("abort");
                repeat (3) @(posedge clk);
                @(negedge clk);
                rst        = 1'b0;
                model_regs = '0;
                last_start = 0;
                mon_en     = 1'b1;
                for (int k = 0; k < NCH && ok; k++) applyStimulus(k, 1'b0, ok);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
